// File: rtl/ysyx_24110015_hazard_ctrl.sv
// Issue/retire hazard controller: RAW scoreboard, in-flight limit, serial-op gating,
// and a redirect/flush sequencer driven by EXU mispredictions.

module ysyx_24110015_hazard_ctrl_pend (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] cnt
);
  // Saturating in both directions; simultaneous inc/dec cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              cnt <= '0;
    else if (inc && !dec && cnt != 2'd3)     cnt <= cnt + 2'd1;
    else if (dec && !inc && cnt != 2'd0)     cnt <= cnt - 2'd1;
  end
endmodule

module ysyx_24110015_hazard_ctrl #(
  parameter int MAX_INFLIGHT = 3,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_serial,
  input  logic        exu_ready,
  output logic        issue_allow,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regwrite,
  input  logic        ctrl_hazard,
  input  logic [31:0] pc_next,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  inflight_cnt,
  output logic        busy
);
  localparam logic [2:0] MAX_W   = 3'(MAX_INFLIGHT);
  localparam logic [1:0] FC_INIT = 2'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state, state_n;
  logic [1:0]       flush_cnt;
  logic             first;
  logic [31:0][1:0] pend;
  logic [1:0]       pend_rs1, pend_rs2;
  logic             raw, issue_fire, wb_fire;

  // x0 is never tracked, so its slot reads as constant zero.
  assign pend[0] = '0;

  for (genvar r = 1; r < 32; r++) begin : g_pend
    ysyx_24110015_hazard_ctrl_pend u_pend (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (issue_fire & id_regwrite & (id_rd == 5'(r))),
      .dec   (wb_fire & wb_regwrite & (wb_rd == 5'(r))),
      .cnt   (pend[r])
    );
  end

  assign pend_rs1 = pend[id_rs1];
  assign pend_rs2 = pend[id_rs2];
  assign raw = (id_rs1_used && id_rs1 != '0 && pend_rs1 != '0) ||
               (id_rs2_used && id_rs2 != '0 && pend_rs2 != '0);

  assign issue_allow = (state == IDLE) && !ctrl_hazard && !raw &&
                       ({1'b0, inflight_cnt} < MAX_W) &&
                       (!id_serial || inflight_cnt == '0);
  assign issue_fire  = id_valid & exu_ready & issue_allow;
  // A retirement with nothing in flight is spurious and dropped entirely.
  assign wb_fire     = wb_valid & (inflight_cnt != '0);
  assign busy        = inflight_cnt != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_cnt <= '0;
    end else begin
      case ({issue_fire, wb_fire})
        2'b10:   inflight_cnt <= inflight_cnt + 2'd1;
        2'b01:   inflight_cnt <= inflight_cnt - 2'd1;
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      flush_cnt   <= '0;
      first       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state <= state_n;
      if (ctrl_hazard) begin
        flush_cnt   <= FC_INIT;
        first       <= 1'b1;
        redirect_pc <= pc_next;
      end else if (state == FLUSH) begin
        first <= 1'b0;
        if (flush_cnt != '0) flush_cnt <= flush_cnt - 2'd1;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ctrl_hazard) state_n = FLUSH;
      FLUSH:   if (ctrl_hazard) state_n = FLUSH;
               else if (flush_cnt == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    flush          = (state == FLUSH);
    redirect_valid = (state == FLUSH) && first;
  end
endmodule
